// File: rtl/memory_responder.sv
// Memory-side responder for the single-port processor bus: byte-lane RAM plus an MMIO window
// with an LED register, a 64-bit cycle counter (coherent hi/lo reads) and a byte TX FIFO.
module memory_responder #(
  parameter int unsigned RAM_WORDS  = 4096,
  parameter logic [31:0] MMIO_BASE  = 32'hF000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  // Counter value loaded on reset; zero in normal use.
  parameter logic [63:0] CNT_INIT   = 64'd0
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  wr_mask_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [7:0]  led_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int          RAM_AW     = $clog2(RAM_WORDS);
  localparam int          FIFO_AW    = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS * 4);
  localparam logic [FIFO_AW:0] FULL_COUNT = FIFO_DEPTH[FIFO_AW:0];

  logic [31:0]       ram [RAM_WORDS];
  logic [7:0]        fifo_mem [FIFO_DEPTH];

  logic [63:0]       cnt;
  logic [31:0]       cnt_hi_shadow;
  logic [7:0]        led;
  logic              ovf;
  logic [FIFO_AW:0]  wr_ptr;
  logic [FIFO_AW:0]  rd_ptr;
  logic [FIFO_AW:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [31:0]       count_ext;
  logic [2:0]        count_field;
  logic [31:0]       status_word;
  logic [31:0]       rd_word;

  logic              ram_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [29:0]       word_off;
  logic              led_sel;
  logic              lo_sel;
  logic              hi_sel;
  logic              tx_sel;
  logic              status_sel;

  logic              push;
  logic              pop;
  logic              push_ok;
  logic              ovf_set;
  logic              ovf_clr;
  logic              unused_addr;

  assign unused_addr = ^addr_i[1:0];

  // RAM takes priority should the MMIO window ever be placed inside it.
  assign ram_hit    = addr_i < RAM_BYTES;
  assign ram_idx    = addr_i[RAM_AW+1:2];
  assign word_off   = addr_i[31:2] - MMIO_BASE[31:2];
  assign led_sel    = !ram_hit && (word_off == 30'd0);
  assign lo_sel     = !ram_hit && (word_off == 30'd1);
  assign hi_sel     = !ram_hit && (word_off == 30'd2);
  assign tx_sel     = !ram_hit && (word_off == 30'd3);
  assign status_sel = !ram_hit && (word_off == 30'd4);

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign count_ext  = 32'(fifo_count);

  always_comb begin
    count_field = 3'd7;
    if (count_ext <= 32'd7) count_field = count_ext[2:0];
  end

  assign status_word = {25'd0, count_field, 1'b0, ovf, fifo_full, fifo_empty};

  assign push    = we_i && tx_sel && wr_mask_i[0];
  assign pop     = tx_valid_o && tx_ready_i;
  assign push_ok = push && (!fifo_full || pop);
  assign ovf_set = push && fifo_full && !pop;
  assign ovf_clr = we_i && status_sel && wr_mask_i[0] && data_i[2];

  assign tx_valid_o = !fifo_empty;
  assign tx_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[FIFO_AW-1:0]];
  assign led_o      = led;

  always_comb begin
    rd_word = 32'd0;
    if (ram_hit)         rd_word = ram[ram_idx];
    else if (led_sel)    rd_word = {24'd0, led};
    else if (lo_sel)     rd_word = cnt[31:0];
    else if (hi_sel)     rd_word = cnt_hi_shadow;
    else if (status_sel) rd_word = status_word;
  end

  // RAM is not reset; the array read above sees the pre-write word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (we_i && ram_hit && reset_n_i) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_mask_i[k]) ram[ram_idx][8*k +: 8] <= data_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= data_i[7:0];
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_o        <= 32'd0;
      led           <= 8'd0;
      cnt           <= CNT_INIT;
      cnt_hi_shadow <= 32'd0;
      ovf           <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      data_o <= rd_word;
      cnt    <= cnt + 64'd1;
      if (lo_sel) cnt_hi_shadow <= cnt[63:32];
      if (we_i && led_sel && wr_mask_i[0]) led <= data_i[7:0];
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a bus-level model (byte map, queue, counter) is checked
// against the DUT every cycle, plus hand-computed literal expectations from the test plan.
module tb_memory_responder;

  localparam int unsigned RW    = 4096;
  localparam logic [31:0] BASE  = 32'hF000_0000;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] INIT  = 64'h0000_0001_FFFF_FFF0;
  localparam logic [31:0] IDLE_A   = 32'h8000_0000;
  localparam logic [31:0] A_LED    = BASE + 32'h00;
  localparam logic [31:0] A_CNT_LO = BASE + 32'h04;
  localparam logic [31:0] A_CNT_HI = BASE + 32'h08;
  localparam logic [31:0] A_TX     = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] addr = IDLE_A;
  logic        we = 1'b0;
  logic [3:0]  mask = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        tx_ready = 1'b0;
  logic [31:0] data_o;
  logic [7:0]  led_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;

  int n_err = 0;
  int n_checks = 0;
  bit chk_en = 1'b0;

  memory_responder #(
    .RAM_WORDS (RW),
    .MMIO_BASE (BASE),
    .FIFO_DEPTH(DEPTH),
    .CNT_INIT  (INIT)
  ) dut (
    .clk       (clk),
    .reset_n_i (rst_n),
    .addr_i    (addr),
    .we_i      (we),
    .wr_mask_i (mask),
    .data_i    (wdata),
    .data_o    (data_o),
    .led_o     (led_o),
    .tx_data_o (tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready)
  );

  always #5 clk = ~clk;

  // Behavioural model: byte-addressed memory, plain registers and a queue for the FIFO.
  logic [7:0]  ram_b [int unsigned];
  logic [7:0]  q [$];
  logic [7:0]  m_led = 8'd0;
  logic [63:0] m_cnt = INIT;
  logic [31:0] m_hi = 32'd0;
  bit          m_ovf = 1'b0;
  logic [31:0] exp_data = 32'd0;
  bit          exp_known = 1'b1;
  int          edges = 0;

  logic [31:0] m_a;
  logic [31:0] m_off;
  bit          m_mm;
  bit          m_push;
  bit          m_pop;
  bit          m_drop;
  logic [31:0] m_rd;
  bit          m_known;

  function automatic logic [31:0] model_status();
    int n;
    logic [31:0] s;
    n = q.size();
    s = 32'd0;
    s[0] = (n == 0);
    s[1] = (n == int'(DEPTH));
    s[2] = m_ovf;
    s[6:4] = 3'((n > 7) ? 7 : n);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_led = 8'd0;
      m_cnt = INIT;
      m_hi = 32'd0;
      m_ovf = 1'b0;
      exp_data = 32'd0;
      exp_known = 1'b1;
      edges = 0;
    end else begin
      m_a = addr & ~32'd3;
      m_mm = (m_a >= BASE) && ((m_a - BASE) < 32'h14);
      m_off = m_a - BASE;
      m_rd = 32'd0;
      m_known = 1'b1;
      if (m_a < RW * 4) begin
        for (int k = 0; k < 4; k++) begin
          if (ram_b.exists(m_a + k)) m_rd[8*k +: 8] = ram_b[m_a + k];
          else m_known = 1'b0;
        end
      end else if (m_mm) begin
        case (m_off)
          32'h00: m_rd = {24'd0, m_led};
          32'h04: m_rd = m_cnt[31:0];
          32'h08: m_rd = m_hi;
          32'h10: m_rd = model_status();
          default: m_rd = 32'd0;
        endcase
      end
      m_push = we && m_mm && (m_off == 32'h0C) && mask[0];
      m_pop  = (q.size() != 0) && tx_ready;
      m_drop = m_push && (q.size() == int'(DEPTH)) && !m_pop;
      if (m_pop) void'(q.pop_front());
      if (m_push && !m_drop) q.push_back(wdata[7:0]);
      if (m_drop) m_ovf = 1'b1;
      else if (we && m_mm && (m_off == 32'h10) && mask[0] && wdata[2]) m_ovf = 1'b0;
      if (we && m_mm && (m_off == 32'h00) && mask[0]) m_led = wdata[7:0];
      if (we && (m_a < RW * 4)) begin
        for (int k = 0; k < 4; k++) if (mask[k]) ram_b[m_a + k] = wdata[8*k +: 8];
      end
      if (m_mm && (m_off == 32'h04)) m_hi = m_cnt[63:32];
      m_cnt = m_cnt + 64'd1;
      exp_data = m_rd;
      exp_known = m_known;
      edges++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_known) check("model data_o", data_o, exp_data);
      check("model led_o", {24'd0, led_o}, {24'd0, m_led});
      check("model tx_valid_o", {31'd0, tx_valid_o}, {31'd0, q.size() != 0});
      check("model tx_data_o", {24'd0, tx_data_o}, {24'd0, (q.size() != 0) ? q[0] : 8'h00});
    end
  end

  task automatic step(input logic [31:0] a, input logic w, input logic [3:0] m, input logic [31:0] d);
    addr = a;
    we = w;
    mask = m;
    wdata = d;
    @(negedge clk);
    addr = IDLE_A;
    we = 1'b0;
    mask = 4'd0;
    wdata = 32'd0;
  endtask

  logic [7:0] got [$];
  logic [7:0] exp_b [4];

  task automatic drain_check(input string name);
    for (int i = 0; i < 12 && tx_valid_o; i++) begin
      got.push_back(tx_data_o);
      step(IDLE_A, 1'b0, 4'd0, 32'd0);
    end
    check({name, " count"}, got.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check({name, " byte"}, (i < got.size()) ? {24'd0, got[i]} : 32'hDEAD, {24'd0, exp_b[i]});
    check({name, " empty after"}, {31'd0, tx_valid_o}, 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset data_o", data_o, 32'd0);
    check("reset led_o", {24'd0, led_o}, 32'd0);
    check("reset tx_valid_o", {31'd0, tx_valid_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(32'h0, 1'b0, 4'd0, 32'd0);
    step(A_STATUS, 1'b0, 4'd0, 32'd0);
    check("status after reset", data_o, 32'h0000_0001);

    step(32'h100, 1'b1, 4'b1111, 32'hAABB_CCDD);
    step(32'h100, 1'b1, 4'b0010, 32'h0000_1100);
    check("read-before-write", data_o, 32'hAABB_CCDD);
    step(32'h100, 1'b0, 4'd0, 32'd0);
    check("ram lane merge", data_o, 32'hAABB_11DD);

    step(A_CNT_HI, 1'b0, 4'd0, 32'd0);
    check("hi shadow at reset", data_o, 32'd0);
    for (int i = 0; i < 40 && edges < 15; i++) step(IDLE_A, 1'b0, 4'd0, 32'd0);
    check("edge position", edges, 32'd15);
    step(A_CNT_LO, 1'b0, 4'd0, 32'd0);
    check("cnt_lo", data_o, 32'hFFFF_FFFF);
    repeat (3) step(IDLE_A, 1'b0, 4'd0, 32'd0);
    step(A_CNT_HI, 1'b0, 4'd0, 32'd0);
    check("cnt_hi coherent", data_o, 32'h0000_0001);

    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(A_TX, 1'b1, 4'b0001, 32'h41 + i);
    step(A_STATUS, 1'b0, 4'd0, 32'd0);
    check("status full+ovf", data_o, 32'h0000_0046);
    check("head while stalled", {24'd0, tx_data_o}, 32'h41);
    tx_ready = 1'b1;
    got.delete();
    exp_b = '{8'h41, 8'h42, 8'h43, 8'h44};
    drain_check("drain");
    step(A_STATUS, 1'b1, 4'b0001, 32'h4);
    check("status before clear", data_o, 32'h0000_0005);
    step(A_STATUS, 1'b0, 4'd0, 32'd0);
    check("status after clear", data_o, 32'h0000_0001);

    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(A_TX, 1'b1, 4'b0001, 32'h61 + i);
    check("full head", {24'd0, tx_data_o}, 32'h61);
    tx_ready = 1'b1;
    step(A_TX, 1'b1, 4'b0001, 32'h55);
    got.delete();
    got.push_back(tx_data_o);
    step(A_STATUS, 1'b0, 4'd0, 32'd0);
    check("full push+pop status", data_o, 32'h0000_0042);
    exp_b = '{8'h62, 8'h63, 8'h64, 8'h55};
    drain_check("push+pop drain");

    tx_ready = 1'b0;
    step(A_LED, 1'b1, 4'b0001, 32'h5A);
    step(A_LED, 1'b1, 4'b0010, 32'hFF);
    step(BASE + 32'h20, 1'b1, 4'b1111, 32'h1234_5678);
    step(BASE + 32'h20, 1'b0, 4'd0, 32'd0);
    check("unmapped read", data_o, 32'd0);
    check("led value", {24'd0, led_o}, 32'h5A);
    step(A_TX, 1'b1, 4'b0001, 32'h77);
    check("valid before reset", {31'd0, tx_valid_o}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async reset led_o", {24'd0, led_o}, 32'd0);
    check("async reset tx_valid_o", {31'd0, tx_valid_o}, 32'd0);
    check("async reset tx_data_o", {24'd0, tx_data_o}, 32'd0);
    check("async reset data_o", data_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(A_STATUS, 1'b0, 4'd0, 32'd0);
    check("status after mid reset", data_o, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the processor's single-port memory bus (`addr`/`we`/`wr_mask`/write data/read data).
- Contains:
  - an on-chip RAM with byte-lane writes;
  - an MMIO window holding an LED register, a 64-bit cycle counter with coherent hi/lo reads, and a 4-entry byte TX FIFO with a valid/ready output.
- Sits between the processor and the board pins. It is the only slave on the bus.

Parameters:
- RAM_WORDS, 4096, RAM depth in 32-bit words (power of two); RAM occupies byte addresses 0 .. 4*RAM_WORDS-1.
- MMIO_BASE, 32'hF000_0000, base byte address of the MMIO window.
- FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n_i  in  1  asynchronous active-low reset
- addr_i  in  32  byte address from processor; bits [1:0] ignored for decode
- we_i  in  1  write strobe, one cycle per store
- wr_mask_i  in  4  byte-lane enables, already shifted to the lane
- data_i  in  32  write data, already lane-aligned
- data_o  out  32  registered read data for the word at addr_i of previous cycle
- led_o  out  8  LED register
- tx_data_o  out  8  FIFO head byte
- tx_valid_o  out  1  FIFO non-empty
- tx_ready_i  in  1  sink accepts head when high with tx_valid_o

Behaviour:
- Reset (async assert, sync release):
  - data_o=0, led_o=0, counter=0, hi shadow=0;
  - FIFO empty (tx_valid_o=0, tx_data_o=0), overflow sticky=0.
  - RAM contents are not reset.
- Read latency 1:
  - every cycle, data_o <= word selected by addr_i[31:2], independent of we_i;
  - full 32-bit word is returned; the processor does lane shift and sign extension.
- Address decode (word offset from MMIO_BASE):
  - RAM: addr_i < 4*RAM_WORDS; index = addr_i[31:2] mod RAM_WORDS.
  - 0x00 LED: RW, bits [7:0]; write updates only if wr_mask_i[0]; read returns {24'b0, led}.
  - 0x04 CNT_LO: RO; read returns counter[31:0] and, on the same edge, loads hi shadow <= counter[63:32].
  - 0x08 CNT_HI: RO; returns hi shadow.
  - 0x0C TX: WO; write with wr_mask_i[0] pushes data_i[7:0]; reads return 0.
  - 0x10 STATUS: bit0 empty, bit1 full, bit2 overflow sticky, bits[6:4] count, others 0. Write with wr_mask_i[0] and data_i[2]=1 clears overflow.
  - All other addresses: read 0, writes ignored, no error.
- RAM writes: on we_i, each lane k with wr_mask_i[k]=1 updates byte k. Read and write to the same word in the same cycle return old data (read-before-write).
- Counter: 64-bit free-running, +1 every cycle, wraps 2^64-1 → 0. The value returned by CNT_LO is the pre-increment value of that edge.
- TX FIFO:
  - Push = we_i & TX hit & wr_mask_i[0]. Pop = tx_valid_o & tx_ready_i.
  - Push when not full: accepted; count+1.
  - Push when full and pop in the same cycle: accepted; count unchanged.
  - Push when full and no pop: byte dropped; overflow <= 1.
  - Push into empty: tx_valid_o rises next cycle (no bypass).
  - Simultaneous push and pop when not empty: count unchanged; order preserved.
  - Overflow set and clear in the same cycle: set wins.
  - tx_data_o/tx_valid_o must hold stable while tx_valid_o & !tx_ready_i.
- Pointers: log2(FIFO_DEPTH) bits plus a wrap bit. Count field saturates at its width. Default depth is 4, and count 4 fits in bits [6:4].
- Reset mid-operation: FIFO and registers clear immediately on assertion. In-flight writes are lost.

Test Plan:
- Reset, then read RAM word 0 and MMIO 0x10 → data_o=0x0000_0001 for STATUS, led_o=0, tx_valid_o=0.
- Write 0xAABBCCDD to RAM 0x100 mask 4'b1111, then 0x0000_1100 mask 4'b0010 → read 0x100 returns 0xAABB11DD one cycle after address.
- Read CNT_LO at counter value 0x0000_0001_FFFF_FFFF → data_o=0xFFFF_FFFF; a later CNT_HI read returns 0x0000_0001 although the counter has advanced.
- Push 0x41,0x42,0x43,0x44,0x45 with tx_ready_i=0:
  - STATUS reads 0x46 (count 4, full, overflow);
  - then raise tx_ready_i → 0x41..0x44 emitted in order, then tx_valid_o=0.
- FIFO full with tx_ready_i=1, push 0x55 in the same cycle as a pop → accepted; overflow stays 0; 0x55 emerges last.
- Write LED 0x5A, then read 0xF000_0020 (unmapped) → led_o=0x5A, data_o=0. Assert reset_n_i=0 mid-operation → led_o=0 and tx_valid_o=0 without a clock edge.
